systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
Read-out end of the output-stationary systolic array. On a capture pulse it snapshots all ROWS×COLS PE accumulators in one cycle. It then requantizes each value (round, arithmetic shift, saturate) and streams the elements row-major over a valid/ready interface to the writeback path. The snapshot frees the array, so it can clear and start the next tile while the drain streams.

Parameters:
ROWS, 4, array rows
COLS, 4, array columns
ACC_WIDTH, 32, PE accumulator width (signed)
OUT_WIDTH, 16, requantized output width (signed), must be ≤ ACC_WIDTH
SHIFT_W, $clog2(ACC_WIDTH), width of shift control

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
capture  in  1  pulse: snapshot results_in
shift  in  SHIFT_W  right-shift amount, sampled with capture
results_in  in  ROWS*COLS*ACC_WIDTH  PE results, flat; element (r,c) at bit offset (r*COLS+c)*ACC_WIDTH
capture_ack  out  1  1-cycle pulse: capture accepted
capture_drop  out  1  1-cycle pulse: capture ignored (busy)
busy  out  1  snapshot held / streaming in progress
m_valid  out  1  output element valid
m_ready  in  1  downstream ready
m_data  out  OUT_WIDTH  requantized element
m_row  out  $clog2(ROWS) (min 1)  row index of m_data
m_col  out  $clog2(COLS) (min 1)  column index of m_data
m_sat  out  1  element was saturated
m_last  out  1  final element of tile (ROWS-1, COLS-1)

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low. Reset clears every output and flop to 0, FSM to IDLE. Reset mid-stream abandons the tile; no partial output follows.
- FSM states:
  - IDLE: busy=0, m_valid=0.
  - On capture in IDLE: load snapshot and shift; capture_ack=1 next cycle; go to LOAD.
  - LOAD (1 cycle): register element (0,0) into the output stage, m_valid=1; go to STREAM.
  - STREAM: a transfer occurs when m_valid && m_ready.
    - On a transfer of a non-last element: the next element is loaded in the same edge, so m_valid stays 1 (full throughput, 1 element/cycle).
    - On a transfer with m_last=1: m_valid=0, go to IDLE.
- Timing and ordering:
  - busy=1 from the cycle after capture until the cycle after the last transfer.
  - Latency: capture at edge T → m_valid=1 after edge T+2 (first data visible in cycle T+2).
  - Order is row-major: (0,0),(0,1)…(0,COLS-1),(1,0)…; the col counter wraps to 0 and increments row.
- Backpressure:
  - m_valid && !m_ready holds m_data, m_row, m_col, m_sat and m_last stable.
  - m_valid never drops without a transfer.
- Capture while busy (LOAD/STREAM): ignored; capture_drop pulses 1 cycle; snapshot unchanged.
- Capture in the same cycle as the final transfer: dropped (busy still 1). The next capture is accepted only in IDLE.
- Requantization, per element, computed in ACC_WIDTH+1 bits signed:
  - if shift==0, the value is acc unchanged;
  - otherwise the value is (acc + 2^(shift-1)) >>> shift (round-half-up toward +inf).
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; m_sat=1 when clamped.
- shift is captured with the snapshot; changes during streaming have no effect.
- The SVA block, excluded from synthesis, must assert:
  - output stability under backpressure;
  - m_last only at (ROWS-1, COLS-1);
  - capture_ack and capture_drop never simultaneously 1;
  - exactly ROWS*COLS transfers per accepted capture.

Decomposition:
- Shared package tpu_pkg holds:
  - typedef acc_t (signed ACC_WIDTH);
  - typedef out_t (signed OUT_WIDTH);
  - drain FSM enum drain_state_e {IDLE, LOAD, STREAM};
  - function sat_round_shift(acc, shift) returning {sat, value}.
- One sub-module, requant_unit: combinational round/shift/saturate, reusable by other writeback paths.
- Top: snapshot register array, row/col counters, FSM, output stage.

Test Plan:
1. Basic tile, ROWS=COLS=4: element (r,c)=r*4+c, shift=0, m_ready=1, capture at cycle 0 → m_valid from cycle 2; 16 consecutive beats with data 0..15; m_last only on beat 15; busy drops in cycle 18.
2. Rounding: acc values 5, -5, 6, -6 with shift=1 → 3, -2, 3, -3; m_sat=0 on all.
3. Saturation, OUT_WIDTH=16, shift=0:
   - acc 40000 → 32767, m_sat=1;
   - acc -40000 → -32768, m_sat=1;
   - acc 32767 → 32767, m_sat=0.
4. Backpressure: m_ready toggling 1,0,0,1,… → outputs stable while stalled; order intact; exactly 16 transfers; no duplicated or skipped index.
5. Capture while busy: second capture at cycle 5 with different results_in and shift → capture_drop pulses; stream carries the original snapshot. A capture after returning to IDLE gives capture_ack and the new data.
6. Reset mid-stream: assert rst_n=0 after beat 7 → all outputs 0 immediately, FSM IDLE. A fresh capture restarts at (0,0) with a full 16 beats.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and the requantization arithmetic used by the systolic array writeback paths.
package tpu_pkg;

   localparam int ACC_W_DEF = 32;
   localparam int OUT_W_DEF = 16;
   localparam int WIDE      = 64;

   typedef logic signed [ACC_W_DEF-1:0] acc_t;
   typedef logic signed [OUT_W_DEF-1:0] out_t;
   typedef logic signed [WIDE-1:0]      wide_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STREAM
   } drain_state_e;

   typedef struct packed {
      logic  sat;
      wide_t value;
   } requant_t;

   // Index width for a counter over n items, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Round-half-up, arithmetic shift right, saturate to out_w signed bits.
   // The accumulator arrives sign-extended to 64 bits, so adding the rounding
   // constant cannot overflow for any accumulator up to 62 bits wide.
   function automatic requant_t sat_round_shift(input wide_t acc, input logic [7:0] shift,
                                                input int out_w);
      wide_t    rnd;
      wide_t    sum;
      wide_t    hi;
      wide_t    lo;
      requant_t r;
      rnd = (shift == 8'd0) ? '0 : (wide_t'(1) <<< (shift - 8'd1));
      sum = (acc + rnd) >>> shift;
      hi  = (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
      lo  = -(wide_t'(1) <<< (out_w - 1));
      r.sat = 1'b0;
      r.value = sum;
      if (sum > hi) begin
         r.sat   = 1'b1;
         r.value = hi;
      end else if (sum < lo) begin
         r.sat   = 1'b1;
         r.value = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/systolic_result_drain_requant.sv
// Combinational round/shift/saturate of one accumulator to the output width.
module requant_unit
   import tpu_pkg::*;
#(
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT_W   = $clog2(ACC_WIDTH)
) (
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [SHIFT_W-1:0]   shift,
   output logic [OUT_WIDTH-1:0] data,
   output logic                 sat
);

   requant_t res;

   // NOTE: every output of a combinational block is assigned on every path,
   // otherwise synthesis infers a latch to hold the missing case.
   always_comb begin
      res  = sat_round_shift(wide_t'($signed(acc)), 8'(shift), OUT_WIDTH);
      data = res.value[OUT_WIDTH-1:0];
      sat  = res.sat;
   end

`ifndef SYNTHESIS
   // After clamping, the wide result must be exactly the sign extension of data.
   always_comb assert (res.value == wide_t'($signed(data)));
`endif

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots all PE accumulators on capture and streams requantized elements row-major over valid/ready.
module systolic_result_drain
   import tpu_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 4,
   parameter int ACC_WIDTH = 32,
   parameter int OUT_WIDTH = 16,
   parameter int SHIFT_W   = $clog2(ACC_WIDTH)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           capture,
   input  logic [SHIFT_W-1:0]             shift,
   input  logic [ROWS*COLS*ACC_WIDTH-1:0] results_in,
   output logic                           capture_ack,
   output logic                           capture_drop,
   output logic                           busy,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic [OUT_WIDTH-1:0]           m_data,
   output logic [idx_w(ROWS)-1:0]         m_row,
   output logic [idx_w(COLS)-1:0]         m_col,
   output logic                           m_sat,
   output logic                           m_last
);

   localparam int N  = ROWS * COLS;
   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);
   localparam int IW = idx_w(N);

   drain_state_e         state;
   logic [ACC_WIDTH-1:0] snap [N];
   logic [SHIFT_W-1:0]   shift_q;

   logic [RW-1:0]        sel_row;
   logic [CW-1:0]        sel_col;
   logic [IW-1:0]        sel_idx;
   logic                 sel_last;
   logic                 load_out;
   logic [OUT_WIDTH-1:0] rq_data;
   logic                 rq_sat;

   // Element to place in the output stage: (0,0) in LOAD, the successor of the
   // element currently on the bus while streaming.
   always_comb begin
      sel_row = '0;
      sel_col = '0;
      if (state == STREAM) begin
         if (m_col == CW'(COLS - 1)) begin
            sel_row = m_row + 1'b1;
         end else begin
            sel_row = m_row;
            sel_col = m_col + 1'b1;
         end
      end
      sel_idx  = IW'(int'(sel_row) * COLS + int'(sel_col));
      sel_last = (sel_row == RW'(ROWS - 1)) && (sel_col == CW'(COLS - 1));
      load_out = (state == LOAD) || ((state == STREAM) && m_valid && m_ready && !m_last);
   end

   requant_unit #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT_W   (SHIFT_W)
   ) u_requant (
      .acc   (snap[sel_idx]),
      .shift (shift_q),
      .data  (rq_data),
      .sat   (rq_sat)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         shift_q      <= '0;
         capture_ack  <= 1'b0;
         capture_drop <= 1'b0;
         busy         <= 1'b0;
         m_valid      <= 1'b0;
         m_data       <= '0;
         m_row        <= '0;
         m_col        <= '0;
         m_sat        <= 1'b0;
         m_last       <= 1'b0;
         // NOTE: the snapshot is a small flop array, not a RAM, so it can and
         // does take the async reset; a RAM-mapped store would have to skip it.
         for (int i = 0; i < N; i++) snap[i] <= '0;
      end else begin
         capture_ack  <= 1'b0;
         capture_drop <= capture && (state != IDLE);

         case (state)
            IDLE: begin
               if (capture) begin
                  for (int i = 0; i < N; i++) snap[i] <= results_in[i*ACC_WIDTH +: ACC_WIDTH];
                  shift_q     <= shift;
                  capture_ack <= 1'b1;
                  busy        <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               m_valid <= 1'b1;
               state   <= STREAM;
            end
            STREAM: begin
               if (m_valid && m_ready && m_last) begin
                  m_valid <= 1'b0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (load_out) begin
            m_data <= rq_data;
            m_sat  <= rq_sat;
            m_row  <= sel_row;
            m_col  <= sel_col;
            m_last <= sel_last;
         end
      end
   end

`ifndef SYNTHESIS
   int xfer_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                xfer_cnt <= 0;
      else if (state == LOAD)    xfer_cnt <= 0;
      else if (m_valid && m_ready) xfer_cnt <= xfer_cnt + 1;
   end

   a_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_row) &&
                                 $stable(m_col) && $stable(m_sat) && $stable(m_last)));

   a_last_pos: assert property (@(posedge clk) disable iff (!rst_n)
      (m_valid && m_last) |-> (m_row == RW'(ROWS - 1)) && (m_col == CW'(COLS - 1)));

   a_ack_drop: assert property (@(posedge clk) disable iff (!rst_n)
      !(capture_ack && capture_drop));

   a_count_last: assert property (@(posedge clk) disable iff (!rst_n)
      (m_valid && m_ready && m_last) |-> (xfer_cnt == N - 1));

   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      (m_valid && m_ready) |-> (xfer_cnt < N));
`endif

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: table-driven requantization plus stream corner cases.
module tb_systolic_result_drain;

   localparam int N = 16;

   logic         clk;
   logic         rst_n;
   logic         capture;
   logic [4:0]   shift_in;
   logic [511:0] results_in;
   logic         capture_ack;
   logic         capture_drop;
   logic         busy;
   logic         m_valid;
   logic         m_ready;
   logic [15:0]  m_data;
   logic [1:0]   m_row;
   logic [1:0]   m_col;
   logic         m_sat;
   logic         m_last;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_data [N];
   logic        exp_sat  [N];

   typedef struct {
      string       name;
      logic [31:0] acc;
      logic [4:0]  sh;
      logic [15:0] data;
      logic        sat;
   } vec_t;

   vec_t vec [12];

   systolic_result_drain dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .capture      (capture),
      .shift        (shift_in),
      .results_in   (results_in),
      .capture_ack  (capture_ack),
      .capture_drop (capture_drop),
      .busy         (busy),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_row        (m_row),
      .m_col        (m_col),
      .m_sat        (m_sat),
      .m_last       (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_const(input logic [31:0] v);
      for (int i = 0; i < N; i++) results_in[i*32 +: 32] = v;
   endtask

   task automatic start_capture(input logic [4:0] sh, input string tag);
      shift_in = sh;
      capture  = 1'b1;
      step();
      check({tag, " ack"}, capture_ack, 1);
      check({tag, " drop0"}, capture_drop, 0);
      check({tag, " busy"}, busy, 1);
      check({tag, " no early valid"}, m_valid, 0);
      capture    = 1'b0;
      shift_in   = ~sh;
      results_in = {16{32'hDEAD_BEEF}};
      step();
      check({tag, " first valid"}, m_valid, 1);
      check({tag, " ack pulse"}, capture_ack, 0);
   endtask

   // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating;
   // mode 2: ready 1 plus a capture on cycle 3; mode 3: ready 1 plus a capture on the final beat.
   task automatic drain(input int mode, input string tag);
      int          beats;
      int          cyc;
      bit          stalled;
      bit          cap_pend;
      logic [22:0] held;
      beats = 0; cyc = 0; stalled = 1'b0; cap_pend = 1'b0; held = '0;
      while (beats < N && cyc < 200) begin
         m_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if ((mode == 2 && cyc == 3) || (mode == 3 && cyc == N - 1)) begin
            capture  = 1'b1;
            shift_in = 5'd1;
            fill_const(32'd999);
            cap_pend = 1'b1;
         end
         check({tag, " busy"}, busy, 1);
         if (stalled)
            check({tag, " hold"}, {m_valid, m_data, m_row, m_col, m_sat, m_last}, held);
         else
            check({tag, " valid"}, m_valid, 1);
         if (m_valid && m_ready) begin
            check({tag, " data"}, m_data, exp_data[beats]);
            check({tag, " sat"}, m_sat, exp_sat[beats]);
            check({tag, " row"}, m_row, beats / 4);
            check({tag, " col"}, m_col, beats % 4);
            check({tag, " last"}, m_last, beats == N - 1);
            beats++;
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held    = {m_valid, m_data, m_row, m_col, m_sat, m_last};
         end
         step();
         cyc++;
         if (cap_pend) begin
            check({tag, " busy drop"}, capture_drop, 1);
            check({tag, " busy no ack"}, capture_ack, 0);
            capture  = 1'b0;
            cap_pend = 1'b0;
         end
      end
      check({tag, " beats"}, beats, N);
      if (mode != 1) check({tag, " cycles"}, cyc, N);
      check({tag, " idle busy"}, busy, 0);
      check({tag, " idle valid"}, m_valid, 0);
      m_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec[0]  = '{"round +5",    32'd5,            5'd1,  16'd3,      1'b0};
      vec[1]  = '{"round -5",    -32'sd5,          5'd1,  -16'sd2,    1'b0};
      vec[2]  = '{"round +6",    32'd6,            5'd1,  16'd3,      1'b0};
      vec[3]  = '{"round -6",    -32'sd6,          5'd1,  -16'sd3,    1'b0};
      vec[4]  = '{"sat +40000",  32'd40000,        5'd0,  16'h7FFF,   1'b1};
      vec[5]  = '{"sat -40000",  -32'sd40000,      5'd0,  16'h8000,   1'b1};
      vec[6]  = '{"max 32767",   32'd32767,        5'd0,  16'h7FFF,   1'b0};
      vec[7]  = '{"min -32768",  -32'sd32768,      5'd0,  16'h8000,   1'b0};
      vec[8]  = '{"sh31 maxpos", 32'h7FFF_FFFF,    5'd31, 16'd1,      1'b0};
      vec[9]  = '{"sh31 maxneg", 32'h8000_0000,    5'd31, 16'hFFFF,   1'b0};
      vec[10] = '{"sh4 -8 half", -32'sd8,          5'd4,  16'd0,      1'b0};
      vec[11] = '{"sh8 sat",     32'h4000_0000,    5'd8,  16'h7FFF,   1'b1};

      rst_n = 1'b0; capture = 1'b0; shift_in = '0; m_ready = 1'b0; results_in = '0;
      #12;
      check("reset busy", busy, 0);
      check("reset valid", m_valid, 0);
      check("reset outs", {capture_ack, capture_drop, m_data, m_row, m_col, m_sat, m_last}, 0);
      rst_n = 1'b1;
      step();

      // Basic tile: element (r,c) = r*4+c, shift 0, full throughput.
      for (int i = 0; i < N; i++) begin
         results_in[i*32 +: 32] = 32'(i);
         exp_data[i] = 16'(i);
         exp_sat[i]  = 1'b0;
      end
      start_capture(5'd0, "basic");
      drain(0, "basic");

      // Requantization table, one uniform tile per vector.
      foreach (vec[v]) begin
         fill_const(vec[v].acc);
         for (int i = 0; i < N; i++) begin
            exp_data[i] = vec[v].data;
            exp_sat[i]  = vec[v].sat;
         end
         start_capture(vec[v].sh, vec[v].name);
         drain(0, vec[v].name);
      end

      // Backpressure with ready pattern 1,0,0,1.
      for (int i = 0; i < N; i++) begin
         results_in[i*32 +: 32] = 32'(i * 100 - 700);
         exp_data[i] = 16'(i * 100 - 700);
         exp_sat[i]  = 1'b0;
      end
      start_capture(5'd0, "bp");
      drain(1, "bp");

      // Capture while busy is dropped; a capture in IDLE then takes the new data.
      for (int i = 0; i < N; i++) begin
         results_in[i*32 +: 32] = 32'(i + 40);
         exp_data[i] = 16'(i + 40);
         exp_sat[i]  = 1'b0;
      end
      start_capture(5'd0, "busycap");
      drain(2, "busycap");
      fill_const(32'd999);
      for (int i = 0; i < N; i++) exp_data[i] = 16'd500;
      start_capture(5'd1, "recap");
      drain(3, "recap");
      step();
      check("final-beat capture not deferred", {busy, capture_ack, m_valid}, 0);

      // Reset in the middle of a tile, then a fresh full tile.
      for (int i = 0; i < N; i++) begin
         results_in[i*32 +: 32] = 32'(i);
         exp_data[i] = 16'(i);
      end
      start_capture(5'd0, "rst");
      m_ready = 1'b1;
      repeat (8) step();
      check("rst mid position", {m_valid, m_row, m_col}, {1'b1, 2'd2, 2'd0});
      rst_n = 1'b0;
      #1;
      check("rst clears", {busy, m_valid, capture_ack, capture_drop, m_data, m_row, m_col, m_sat, m_last}, 0);
      #2;
      rst_n   = 1'b1;
      m_ready = 1'b0;
      step();
      check("rst stays idle", {busy, m_valid}, 0);
      for (int i = 0; i < N; i++) results_in[i*32 +: 32] = 32'(i);
      start_capture(5'd0, "post-rst");
      drain(0, "post-rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
